// File: rtl/arb_client.sv
`default_nettype none
// ============================================================================
// Module   : arb_client
// Brief    : Requester-side agent for a two-port grant arbiter. Takes one job,
//            requests the bus, streams a 1..2^LEN_W beat burst while granted,
//            stalls on preemption, and abandons the job if no grant arrives.
// Revision : 1.0 - initial release
// ============================================================================
module arb_client #(
   parameter int DATA_W  = 8,
   parameter int LEN_W   = 2,
   parameter int TO_W    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [DATA_W-1:0] job_base,
   input  logic [LEN_W-1:0]  job_len,
   output logic              req,
   input  logic              gnt,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              done,
   output logic              err_timeout
);

   // Last wait-count value before the job is abandoned.
   localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_REL  = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_req;
   logic                r_done;
   logic                r_err;
   logic [DATA_W-1:0]   r_base;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_beat;
   logic [TO_W-1:0]     r_wait;

   logic                w_bus_valid;
   logic [DATA_W-1:0]   w_beat_ext;

   // A beat moves only while in XFER and the grant is present this cycle.
   assign w_bus_valid = (r_state == S_XFER) && gnt && !reset;
   assign w_beat_ext  = DATA_W'(r_beat);

   assign job_ready   = (r_state == S_IDLE) && !reset;
   assign bus_valid   = w_bus_valid;
   assign bus_data    = r_base + w_beat_ext;
   assign req         = r_req;
   assign done        = r_done;
   assign err_timeout = r_err;

   // Control FSM; req, done and err_timeout are registered here.
   // In REQ the wait counter is still zero on the first edge, which is how a
   // grant left over from an earlier owner is ignored on that edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_base  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_wait  <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (job_valid) begin
                  r_base  <= job_base;
                  r_len   <= job_len;
                  r_beat  <= '0;
                  r_wait  <= '0;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (gnt && (r_wait != '0)) begin
                  r_state <= S_XFER;
               end else if (r_wait == C_TO_LAST) begin
                  r_err   <= 1'b1;
                  r_req   <= 1'b0;
                  r_state <= S_REL;
               end else begin
                  r_wait <= r_wait + TO_W'(1);
               end
            end
            S_XFER: begin
               if (gnt) begin
                  if (r_beat == r_len) begin
                     r_req   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_REL;
                  end else begin
                     r_beat <= r_beat + LEN_W'(1);
                  end
               end
            end
            S_REL: begin
               if (!gnt) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arb_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_client
// Brief    : Scoreboard bench for arb_client with a registered-grant arbiter
//            model and directed jobs (burst, wrap, preempt, timeout, stale
//            grant, reset mid-burst).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_client;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       job_valid = 1'b0;
   logic [7:0] job_base  = 8'h00;
   logic [1:0] job_len   = 2'd0;
   logic       gnt       = 1'b0;
   logic       job_ready, req, bus_valid, done, err_timeout;
   logic [7:0] bus_data;

   // Arbiter model controls
   logic preempt   = 1'b0;
   logic stale     = 1'b0;
   logic stuck_low = 1'b0;
   logic prev_req  = 1'b0;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks   = 0;
   int    n_fail     = 0;
   int    beats_seen = 0;
   int    done_seen  = 0;
   int    err_seen   = 0;
   logic  exp_done_next = 1'b0;

   always #5 clock = ~clock;

   arb_client #(.DATA_W(8), .LEN_W(2), .TO_W(4), .TIMEOUT(15)) dut (
      .clock(clock), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_base(job_base), .job_len(job_len),
      .req(req), .gnt(gnt),
      .bus_valid(bus_valid), .bus_data(bus_data),
      .done(done), .err_timeout(err_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered grant: follows req one cycle late, with preempt/stale/stuck overrides.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         gnt      = stuck_low ? 1'b0 : ((prev_req & ~preempt) | stale);
         prev_req = req;
      end
   end

   // Monitor: pops expected beats and checks done timing.
   initial begin
      beat_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (done || exp_done_next) check("done_pulse", {31'd0, done}, {31'd0, exp_done_next});
            if (done || err_timeout) check("done_err_excl", {31'd0, done & err_timeout}, 32'd0);
            if (done) done_seen++;
            if (err_timeout) err_seen++;
            exp_done_next = 1'b0;
            if (bus_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", bus_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", {24'd0, bus_data}, {24'd0, e.data});
                  exp_done_next = e.last;
                  beats_seen++;
               end
            end
         end else begin
            exp_done_next = 1'b0;
         end
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic push_job(input logic [7:0] b, input logic [1:0] l);
      logic [7:0] d;
      for (int i = 0; i <= int'(l); i++) begin
         d = b + 8'(i);
         exp_q.push_back('{data: d, last: (i == int'(l))});
      end
   endtask

   // Offer a job when ready; returns in the first cycle after acceptance.
   task automatic issue(input logic [7:0] b, input logic [1:0] l, input bit expect_beats);
      int guard = 0;
      while (!job_ready && guard < 200) begin
         step();
         guard++;
      end
      if (!job_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_wait: got job_ready 0 expected 1 within 200 cycles");
      end else begin
         job_valid = 1'b1;
         job_base  = b;
         job_len   = l;
         if (expect_beats) push_job(b, l);
         step();
         job_valid = 1'b0;
         job_base  = 8'hA5;
         job_len   = 2'd0;
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!(job_ready && exp_q.size() == 0) && guard < 200) begin
         step();
         guard++;
      end
      if (!(job_ready && exp_q.size() == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_wait: got %0d beats pending expected 0 and idle", exp_q.size());
      end
   endtask

   task automatic wait_beats(input int target);
      int guard = 0;
      while (beats_seen < target && guard < 200) begin
         step();
         guard++;
      end
      if (beats_seen < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_wait: got %0d beats expected %0d", beats_seen, target);
      end
   endtask

   initial begin
      int start;
      int dstart;
      int guard;

      // Reset state
      step();
      step();
      check("rst_req",       {31'd0, req},         32'd0);
      check("rst_bus_valid", {31'd0, bus_valid},   32'd0);
      check("rst_done",      {31'd0, done},        32'd0);
      check("rst_err",       {31'd0, err_timeout}, 32'd0);
      check("rst_job_ready", {31'd0, job_ready},   32'd0);
      reset = 1'b0;
      step();
      check("idle_job_ready", {31'd0, job_ready}, 32'd1);

      // 1: single burst 10..13 with exact cycle timing
      issue(8'h10, 2'd3, 1'b1);
      check("t1_req_s1",   {31'd0, req},       32'd1);
      check("t1_bv_s1",    {31'd0, bus_valid}, 32'd0);
      step();
      check("t1_bv_s2",    {31'd0, bus_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("t1_bv_burst", {31'd0, bus_valid}, 32'd1);
         check("t1_req_burst", {31'd0, req},      32'd1);
      end
      step();
      check("t1_done",     {31'd0, done},      32'd1);
      check("t1_req_low",  {31'd0, req},       32'd0);
      check("t1_bv_end",   {31'd0, bus_valid}, 32'd0);
      check("t1_not_ready", {31'd0, job_ready}, 32'd0);
      wait_idle();
      check("t1_done_cnt", done_seen, 32'd1);

      // 2: wrap-around FE, FF, 00, 01
      issue(8'hFE, 2'd3, 1'b1);
      wait_idle();

      // 3: preemption for 3 cycles after beat 1
      start = beats_seen;
      issue(8'h30, 2'd3, 1'b1);
      wait_beats(start + 2);
      preempt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t3_stall_bv",  {31'd0, bus_valid}, 32'd0);
         check("t3_stall_req", {31'd0, req},       32'd1);
      end
      preempt = 1'b0;
      wait_idle();
      check("t3_beat_cnt", beats_seen - start, 32'd4);

      // 4: timeout with grant held low
      stuck_low = 1'b1;
      start  = beats_seen;
      dstart = done_seen;
      issue(8'h40, 2'd2, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         check("t4_err", {31'd0, err_timeout}, (k == 16) ? 32'd1 : 32'd0);
         check("t4_req", {31'd0, req},         (k < 16)  ? 32'd1 : 32'd0);
         if (k < 16) step();
      end
      stuck_low = 1'b0;
      wait_idle();
      check("t4_err_cnt",  err_seen,            32'd1);
      check("t4_no_beats", beats_seen - start,  32'd0);
      check("t4_no_done",  done_seen - dstart,  32'd0);

      // 5: stale grant held through REL with the next job already offered
      dstart = done_seen;
      issue(8'h50, 2'd1, 1'b1);
      guard = 0;
      while (done_seen == dstart && guard < 50) begin
         step();
         guard++;
      end
      check("t5_done_seen", done_seen - dstart, 32'd1);
      stale     = 1'b1;
      job_valid = 1'b1;
      job_base  = 8'h60;
      job_len   = 2'd0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("t5_rel_ready", {31'd0, job_ready}, 32'd0);
         check("t5_rel_req",   {31'd0, req},       32'd0);
         check("t5_rel_bv",    {31'd0, bus_valid}, 32'd0);
      end
      stale = 1'b0;
      guard = 0;
      while (!job_ready && guard < 20) begin
         step();
         guard++;
      end
      check("t5_reidle", {31'd0, job_ready}, 32'd1);
      push_job(8'h60, 2'd0);
      step();
      job_valid = 1'b0;
      job_base  = 8'hA5;
      wait_idle();
      check("t5_done_cnt", done_seen - dstart, 32'd2);

      // 6: reset asserted during beat 2
      start = beats_seen;
      issue(8'h70, 2'd3, 1'b1);
      wait_beats(start + 2);
      step();
      check("t6_beat2_bv", {31'd0, bus_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("t6_rst_req",   {31'd0, req},         32'd0);
      check("t6_rst_bv",    {31'd0, bus_valid},   32'd0);
      check("t6_rst_done",  {31'd0, done},        32'd0);
      check("t6_rst_err",   {31'd0, err_timeout}, 32'd0);
      exp_q.delete();
      step();
      reset = 1'b0;
      step();
      check("t6_idle", {31'd0, job_ready}, 32'd1);
      start = beats_seen;
      issue(8'h80, 2'd3, 1'b1);
      wait_idle();
      check("t6_next_beats", beats_seen - start, 32'd4);
      check("final_done_cnt", done_seen, 32'd6);
      check("final_err_cnt",  err_seen,  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/arb_client.md
# arb_client

Requester-side agent for the two-way `arbiter` grant protocol: it accepts one job at a time, raises `req`, waits for `gnt`, and then drives a burst of 1–4 data beats onto the shared bus. While the burst runs it pauses whenever the grant is withdrawn. It drops `req` when the burst completes or when the wait for a grant times out. One instance sits on each requester port (`req_0/gnt_0`, `req_1/gnt_1`) of the arbiter.

## Interface
- `DATA_W`, default 8: width of the job base value and of `bus_data`.
- `LEN_W`, default 2: width of `job_len`. Burst length is `job_len + 1` beats.
- `TO_W`, default 4: width of the wait counter.
- `TIMEOUT`, default 15: cycles spent in REQ without a grant before the job is abandoned. Must satisfy 1 ≤ TIMEOUT ≤ 2^TO_W − 1.

Ports:
- `clock`, in, 1: the single clock. All flops are rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `job_valid`, in, 1: a job is offered.
- `job_ready`, out, 1: the block can take a job. High only in IDLE.
- `job_base`, in, DATA_W: value sent on the first beat.
- `job_len`, in, LEN_W: number of beats minus one.
- `req`, out, 1: request to the arbiter. Registered.
- `gnt`, in, 1: grant from the arbiter. The arbiter registers it, so it responds one cycle after `req`.
- `bus_valid`, out, 1: a beat is on the bus this cycle.
- `bus_data`, out, DATA_W: beat payload.
- `done`, out, 1: one-cycle pulse when the last beat completes.
- `err_timeout`, out, 1: one-cycle pulse when a job is abandoned.

## Operation
- The state machine has four states: IDLE, REQ, XFER, REL.
- Reset values: state = IDLE; `req`, `done` and `err_timeout` = 0; `base`, `len`, beat counter and wait counter = 0.
- While in reset, `bus_valid` = 0 and `job_ready` = 0.
- IDLE:
  - `job_ready` = 1.
  - On `job_valid & job_ready`: capture `job_base` and `job_len`, clear the beat and wait counters, set `req` ← 1, go to REQ.
- REQ:
  - If `gnt` = 1: go to XFER.
  - Otherwise, if wait counter = TIMEOUT − 1: pulse `err_timeout`, set `req` ← 0, go to REL.
  - Otherwise: increment the wait counter.
  - `gnt` is sampled only from the second REQ cycle onward, so a `gnt` that was still high when REQ was entered is ignored.
- XFER:
  - `bus_valid` = (state == XFER) & `gnt`. This output is combinational from `gnt`.
  - `bus_data` = `base + beat`, truncated to DATA_W bits, so it wraps (for example, 8'hFF + 1 → 8'h00).
  - On each edge with `bus_valid` = 1: if beat == `len`, set `req` ← 0, pulse `done`, go to REL. Otherwise increment the beat counter.
  - If `gnt` = 0 during XFER (grant preempted by the higher-priority port): stall. `req` stays 1, the beat counter holds, and the burst resumes with the same beat when `gnt` returns. XFER has no timeout.
- REL:
  - `req` = 0.
  - Stay in REL until `gnt` = 0 is sampled, then go to IDLE.
  - The minimum time in REL is 1 cycle. This prevents a stale grant from being read as a grant for the next job.
- `done` and `err_timeout` are never high in the same cycle.
- Job fields are held internally, so the inputs may change once the job has been accepted.
- Reset asserted mid-operation clears everything asynchronously. `req` drops in the same cycle and the job in progress is lost; no `done` or `err_timeout` pulse is produced.

## Timing
- Job accepted at edge t → `req` = 1 from t.
- With the arbiter's registered grant, `gnt` = 1 from t+1.
- XFER is entered at the second REQ edge that sees `gnt` = 1, i.e. t+2; the first beat is in the cycle after t+2.
- An N-beat burst with no preemption occupies N consecutive cycles.
- `done` is asserted in the cycle after the last beat. `req` falls at the same edge.
- The next job can be accepted no earlier than 2 cycles after `done`: 1 cycle in REL with `gnt` = 0, then IDLE.
- A timeout fires at the TIMEOUT-th REQ edge without a grant. `err_timeout` and `req` = 0 appear in the cycle after that edge.

## Test plan
1. **Single burst.** Job with base = 8'h10 and len = 3, arbiter granting normally. Expected: `bus_data` = 10, 11, 12, 13 on 4 consecutive `bus_valid` cycles, then one `done` pulse, `req` low, return to IDLE.
2. **Wrap-around.** base = 8'hFE, len = 3. Expected beats FE, FF, 00, 01.
3. **Preemption.** Drop `gnt` for 3 cycles after beat 1 of a 4-beat burst. Expected: `bus_valid` = 0 for those 3 cycles, `req` held high, the burst resumes with beat 2, and exactly 4 beats total.
4. **Timeout.** `gnt` tied to 0, TIMEOUT = 15. Expected: a single `err_timeout` pulse 15 cycles after REQ is entered, `req` = 0, no beats, no `done`, block returns to IDLE.
5. **Stale grant.** Hold `gnt` = 1 through REL and into the next `job_valid`. Expected: block waits in REL until `gnt` = 0 and no beat is issued before a fresh grant arrives.
6. **Reset mid-burst.** Assert `reset` during beat 2. Expected: `req`, `bus_valid`, `done` and `err_timeout` all 0 in the same cycle, state IDLE, and the next job runs normally.
